// File: rtl/alu_pkg.sv
// rtl/alu_pkg.sv - shared ALU control encoding, default tag width, response register states
package alu_pkg;

  localparam int ALU_CTRL_W    = 12;
  localparam int TAG_W_DEFAULT = 5;

  localparam logic [ALU_CTRL_W-1:0] ALU_ADD  = 12'h800;
  localparam logic [ALU_CTRL_W-1:0] ALU_SUB  = 12'h400;
  localparam logic [ALU_CTRL_W-1:0] ALU_SLT  = 12'h200;
  localparam logic [ALU_CTRL_W-1:0] ALU_SLTU = 12'h100;
  localparam logic [ALU_CTRL_W-1:0] ALU_AND  = 12'h080;
  localparam logic [ALU_CTRL_W-1:0] ALU_NOR  = 12'h040;
  localparam logic [ALU_CTRL_W-1:0] ALU_OR   = 12'h020;
  localparam logic [ALU_CTRL_W-1:0] ALU_XOR  = 12'h010;
  localparam logic [ALU_CTRL_W-1:0] ALU_SLL  = 12'h008;
  localparam logic [ALU_CTRL_W-1:0] ALU_SRL  = 12'h004;
  localparam logic [ALU_CTRL_W-1:0] ALU_SRA  = 12'h002;
  localparam logic [ALU_CTRL_W-1:0] ALU_LUI  = 12'h001;

  typedef enum logic {
    RESP_EMPTY = 1'b0,
    RESP_FULL  = 1'b1
  } resp_state_e;

endpackage

// File: rtl/alu_arbiter_if.sv
// rtl/alu_arbiter_if.sv - request ports, flush and response handshake of alu_arbiter
interface alu_arbiter_if import alu_pkg::*; #(
  parameter int TAG_W = TAG_W_DEFAULT
) ();

  logic                  flush;
  logic                  req0_valid;
  logic                  req0_ready;
  logic [ALU_CTRL_W-1:0] req0_control;
  logic [31:0]           req0_rj;
  logic [31:0]           req0_rk;
  logic [TAG_W-1:0]      req0_tag;
  logic                  req1_valid;
  logic                  req1_ready;
  logic [ALU_CTRL_W-1:0] req1_control;
  logic [31:0]           req1_rj;
  logic [31:0]           req1_rk;
  logic [TAG_W-1:0]      req1_tag;
  logic                  resp_valid;
  logic                  resp_ready;
  logic [31:0]           resp_result;
  logic [TAG_W-1:0]      resp_tag;
  logic                  resp_src;
  logic                  resp_err;

  modport master (
    output flush,
    output req0_valid, req0_control, req0_rj, req0_rk, req0_tag,
    input  req0_ready,
    output req1_valid, req1_control, req1_rj, req1_rk, req1_tag,
    input  req1_ready,
    input  resp_valid, resp_result, resp_tag, resp_src, resp_err,
    output resp_ready
  );

  modport slave (
    input  flush,
    input  req0_valid, req0_control, req0_rj, req0_rk, req0_tag,
    output req0_ready,
    input  req1_valid, req1_control, req1_rj, req1_rk, req1_tag,
    output req1_ready,
    output resp_valid, resp_result, resp_tag, resp_src, resp_err,
    input  resp_ready
  );

endinterface

// File: rtl/alu.sv
// rtl/alu.sv - combinational ALU; each one-hot control bit selects one op, results are OR-combined
module alu import alu_pkg::*; (
  input  logic [ALU_CTRL_W-1:0] alu_control,
  input  logic [31:0]           alu_src1,
  input  logic [31:0]           alu_src2,
  output logic [31:0]           alu_result
);

  logic [31:0] add_r, sub_r, slt_r, sltu_r, and_r, nor_r, or_r, xor_r;
  logic [31:0] sll_r, srl_r, sra_r, lui_r;
  logic [4:0]  shamt;

  assign shamt  = alu_src2[4:0];
  assign add_r  = alu_src1 + alu_src2;
  assign sub_r  = alu_src1 - alu_src2;
  assign slt_r  = {31'd0, $signed(alu_src1) < $signed(alu_src2)};
  assign sltu_r = {31'd0, alu_src1 < alu_src2};
  assign and_r  = alu_src1 & alu_src2;
  assign nor_r  = ~(alu_src1 | alu_src2);
  assign or_r   = alu_src1 | alu_src2;
  assign xor_r  = alu_src1 ^ alu_src2;
  assign sll_r  = alu_src1 << shamt;
  assign srl_r  = alu_src1 >> shamt;
  assign sra_r  = $signed(alu_src1) >>> shamt;
  // lui operand arrives pre-shifted from decode
  assign lui_r  = alu_src2;

  assign alu_result = ({32{alu_control[11]}} & add_r)
                    | ({32{alu_control[10]}} & sub_r)
                    | ({32{alu_control[9]}}  & slt_r)
                    | ({32{alu_control[8]}}  & sltu_r)
                    | ({32{alu_control[7]}}  & and_r)
                    | ({32{alu_control[6]}}  & nor_r)
                    | ({32{alu_control[5]}}  & or_r)
                    | ({32{alu_control[4]}}  & xor_r)
                    | ({32{alu_control[3]}}  & sll_r)
                    | ({32{alu_control[2]}}  & srl_r)
                    | ({32{alu_control[1]}}  & sra_r)
                    | ({32{alu_control[0]}}  & lui_r);

endmodule

// File: rtl/rr_arb2.sv
// rtl/rr_arb2.sv - two-requester round-robin grant; priority moves only when advance is high
module rr_arb2 (
  input  logic       clk,
  input  logic       resetn,
  input  logic [1:0] req,
  input  logic       advance,
  output logic [1:0] grant
);

  logic last_grant;

  assign grant[0] = req[0] & (~req[1] | last_grant);
  assign grant[1] = req[1] & (~req[0] | ~last_grant);

  // Reset to 1 so port 0 wins the first contention
  always_ff @(posedge clk) begin
    if (!resetn) begin
      last_grant <= 1'b1;
    end else if (advance) begin
      last_grant <= grant[1];
    end
  end

endmodule

// File: rtl/alu_arbiter.sv
// rtl/alu_arbiter.sv - shares one ALU between two request ports behind a one-entry response register
module alu_arbiter import alu_pkg::*; #(
  parameter int TAG_W = TAG_W_DEFAULT
) (
  input logic          clk,
  input logic          resetn,
  alu_arbiter_if.slave bus
);

  resp_state_e           state_q, state_d;
  logic [1:0]            req, grant;
  logic                  can_accept, accept;
  logic [ALU_CTRL_W-1:0] sel_control;
  logic [31:0]           sel_rj, sel_rk, alu_out;
  logic [TAG_W-1:0]      sel_tag;
  logic                  sel_onehot;

  assign req = {bus.req1_valid, bus.req0_valid};

  rr_arb2 u_arb (
    .clk     (clk),
    .resetn  (resetn),
    .req     (req),
    .advance (accept),
    .grant   (grant)
  );

  assign can_accept     = resetn & ~bus.flush & ((state_q == RESP_EMPTY) | bus.resp_ready);
  assign bus.req0_ready = grant[0] & can_accept;
  assign bus.req1_ready = grant[1] & can_accept;
  assign accept         = bus.req0_ready | bus.req1_ready;

  assign sel_control = grant[1] ? bus.req1_control : bus.req0_control;
  assign sel_rj      = grant[1] ? bus.req1_rj      : bus.req0_rj;
  assign sel_rk      = grant[1] ? bus.req1_rk      : bus.req0_rk;
  assign sel_tag     = grant[1] ? bus.req1_tag     : bus.req0_tag;
  assign sel_onehot  = (|sel_control) & ~(|(sel_control & (sel_control - 1'b1)));

  alu u_alu (
    .alu_control (sel_control),
    .alu_src1    (sel_rj),
    .alu_src2    (sel_rk),
    .alu_result  (alu_out)
  );

  always_ff @(posedge clk) begin
    if (!resetn) begin
      state_q <= RESP_EMPTY;
    end else begin
      state_q <= state_d;
    end
  end

  // Flush wins over a simultaneous consume; accept implies staying FULL
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      RESP_EMPTY: if (accept) state_d = RESP_FULL;
      RESP_FULL: begin
        if (bus.flush) begin
          state_d = RESP_EMPTY;
        end else if (bus.resp_ready && !accept) begin
          state_d = RESP_EMPTY;
        end
      end
      default: state_d = RESP_EMPTY;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!resetn) begin
      bus.resp_result <= '0;
      bus.resp_tag    <= '0;
      bus.resp_src    <= 1'b0;
      bus.resp_err    <= 1'b0;
    end else if (accept) begin
      bus.resp_result <= alu_out;
      bus.resp_tag    <= sel_tag;
      bus.resp_src    <= grant[1];
      bus.resp_err    <= ~sel_onehot;
    end
  end

  assign bus.resp_valid = (state_q == RESP_FULL);

endmodule
